// File: rtl/ddc_pkg.sv
// Shared types and constants for the DDC retune sequencer.
package ddc_pkg;

    localparam int DDC_DECIM_W = 6;
    localparam int DDC_NCO_W   = 32;
    localparam logic [DDC_DECIM_W-1:0] DDC_MIN_DECIM = 6'd4;

    typedef struct packed {
        logic [DDC_NCO_W-1:0]   freq;
        logic [DDC_DECIM_W-1:0] decim;
        logic                   bypass;
    } ddc_cfg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_APPLY,
        ST_SETTLE,
        ST_RUN
    } tune_state_e;

    // The CIC cannot run below the minimum decimation, so smaller requests are raised.
    function automatic logic [DDC_DECIM_W-1:0] clamp_decim(input logic [DDC_DECIM_W-1:0] d);
        return (d < DDC_MIN_DECIM) ? DDC_MIN_DECIM : d;
    endfunction

endpackage

// File: rtl/ddc_tune_ctrl_if.sv
// Retune request channels from the host register file and the hop scheduler.
interface ddc_tune_ctrl_if #(
    parameter int NCO_WIDTH = 32
);
    import ddc_pkg::*;

    logic                   host_req_valid;
    logic                   host_req_ready;
    logic [NCO_WIDTH-1:0]   host_req_freq;
    logic [DDC_DECIM_W-1:0] host_req_decim;
    logic                   host_req_bypass;

    logic                   hop_req_valid;
    logic                   hop_req_ready;
    logic [NCO_WIDTH-1:0]   hop_req_freq;
    logic [DDC_DECIM_W-1:0] hop_req_decim;
    logic                   hop_req_bypass;

    modport master (
        output host_req_valid, host_req_freq, host_req_decim, host_req_bypass,
        output hop_req_valid, hop_req_freq, hop_req_decim, hop_req_bypass,
        input  host_req_ready, hop_req_ready
    );

    modport slave (
        input  host_req_valid, host_req_freq, host_req_decim, host_req_bypass,
        input  hop_req_valid, hop_req_freq, hop_req_decim, hop_req_bypass,
        output host_req_ready, hop_req_ready
    );

endinterface

// File: rtl/ddc_req_arb.sv
// Two-way fixed-priority retune arbiter: the hop scheduler always wins over the host.
module ddc_req_arb
    import ddc_pkg::*;
(
    input  logic     host_valid,
    input  ddc_cfg_t host_cfg,
    input  logic     hop_valid,
    input  ddc_cfg_t hop_cfg,
    output logic     host_gnt,
    output logic     hop_gnt,
    output logic     any_req,
    output logic     sel_src,
    output ddc_cfg_t sel_cfg
);

    assign hop_gnt  = hop_valid;
    assign host_gnt = host_valid && !hop_valid;
    assign any_req  = host_valid || hop_valid;
    assign sel_src  = hop_valid;
    assign sel_cfg  = hop_valid ? hop_cfg : host_cfg;

endmodule

// File: rtl/ddc_tune_ctrl.sv
// Retune sequencer for ddc_core: drain, apply, settle, then pass the DDC stream through.
// Statistics counters are built only when DDC_TUNE_STATS_EN is defined.
module ddc_tune_ctrl
    import ddc_pkg::*;
#(
    parameter int NCO_WIDTH    = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int CIC_STAGES   = 4,
    parameter int DRAIN_CYCLES = 4,
    parameter int SETTLE_EXTRA = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run_en,
    ddc_tune_ctrl_if.slave          req,
    output logic [NCO_WIDTH-1:0]    ddc_cfg_nco_freq,
    output logic [DDC_DECIM_W-1:0]  ddc_cfg_decimation,
    output logic                    ddc_cfg_bypass_cic,
    output logic                    ddc_cfg_enable,
    input  logic [2*DATA_WIDTH-1:0] s_ddc_tdata,
    input  logic                    s_ddc_tvalid,
    output logic                    s_ddc_tready,
    output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    tune_done,
    output logic                    tune_src,
    output logic                    busy,
    output logic [15:0]             tune_count,
    output logic [15:0]             drop_count
);

    localparam int SETTLE_N = CIC_STAGES + SETTLE_EXTRA;
    localparam int DISC_W   = $clog2(SETTLE_N + 1);
    localparam int DRAIN_W  = $clog2(DRAIN_CYCLES + 1);

    tune_state_e        state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DISC_W-1:0]  disc_cnt;
    ddc_cfg_t           pend_cfg;
    logic               pend_src;

    ddc_cfg_t host_cfg, hop_cfg, sel_cfg;
    logic     host_gnt, hop_gnt, any_req, sel_src;
    logic     sampling, settle_done;

    assign host_cfg = '{freq: DDC_NCO_W'(req.host_req_freq), decim: req.host_req_decim,
                        bypass: req.host_req_bypass};
    assign hop_cfg  = '{freq: DDC_NCO_W'(req.hop_req_freq), decim: req.hop_req_decim,
                        bypass: req.hop_req_bypass};

    ddc_req_arb u_arb (
        .host_valid (req.host_req_valid),
        .host_cfg   (host_cfg),
        .hop_valid  (req.hop_req_valid),
        .hop_cfg    (hop_cfg),
        .host_gnt   (host_gnt),
        .hop_gnt    (hop_gnt),
        .any_req    (any_req),
        .sel_src    (sel_src),
        .sel_cfg    (sel_cfg)
    );

    assign sampling           = (state == ST_IDLE) || (state == ST_RUN);
    assign req.host_req_ready = sampling && host_gnt;
    assign req.hop_req_ready  = sampling && hop_gnt;

    // SETTLE ends on the beat that consumes the last discard, so the next beat is never lost.
    assign settle_done = (disc_cnt == '0) || (s_ddc_tvalid && disc_cnt == DISC_W'(1));

    assign m_axis_tdata   = s_ddc_tdata;
    assign ddc_cfg_enable = ((state == ST_SETTLE) || (state == ST_RUN)) && run_en;

    always_comb begin
        s_ddc_tready  = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state)
            ST_RUN: begin
                s_ddc_tready  = m_axis_tready;
                m_axis_tvalid = s_ddc_tvalid;
            end
            ST_IDLE, ST_DRAIN: s_ddc_tready = 1'b1;
            // With nothing left to discard the beat is held for RUN rather than dropped.
            ST_SETTLE:         s_ddc_tready = (disc_cnt != '0);
            default:           s_ddc_tready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            drain_cnt          <= '0;
            disc_cnt           <= '0;
            pend_cfg           <= '0;
            pend_src           <= 1'b0;
            ddc_cfg_nco_freq   <= '0;
            ddc_cfg_decimation <= DDC_MIN_DECIM;
            ddc_cfg_bypass_cic <= 1'b0;
            tune_done          <= 1'b0;
            tune_src           <= 1'b0;
            busy               <= 1'b0;
        end else begin
            tune_done <= 1'b0;
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (any_req) begin
                        pend_cfg  <= sel_cfg;
                        pend_src  <= sel_src;
                        drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
                        busy      <= 1'b1;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) state <= ST_APPLY;
                    else                 drain_cnt <= drain_cnt - 1'b1;
                end
                ST_APPLY: begin
                    ddc_cfg_nco_freq   <= NCO_WIDTH'(pend_cfg.freq);
                    ddc_cfg_decimation <= clamp_decim(pend_cfg.decim);
                    ddc_cfg_bypass_cic <= pend_cfg.bypass;
                    tune_src           <= pend_src;
                    disc_cnt           <= pend_cfg.bypass ? '0 : DISC_W'(SETTLE_N);
                    state              <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        state     <= ST_RUN;
                        busy      <= 1'b0;
                        tune_done <= 1'b1;
                    end else if (s_ddc_tvalid) begin
                        disc_cnt <= disc_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DDC_TUNE_STATS_EN
    logic drop_beat;
    assign drop_beat = s_ddc_tvalid && s_ddc_tready &&
                       ((state == ST_IDLE) || (state == ST_DRAIN) || (state == ST_SETTLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tune_count <= '0;
            drop_count <= '0;
        end else begin
            if (state == ST_APPLY && tune_count != 16'hFFFF) tune_count <= tune_count + 1'b1;
            if (drop_beat && drop_count != 16'hFFFF)         drop_count <= drop_count + 1'b1;
        end
    end
`else
    assign tune_count = '0;
    assign drop_count = '0;
`endif

endmodule
